// File: rtl/pipe_stage_skid.sv
// Pipeline register with valid/ready handshake and a 2-entry skid buffer.
// in_ready, out_valid and out_data depend only on flops; the instruction field reads as a NOP while empty.
module pipe_stage_skid #(
    parameter int unsigned PAYLOAD_W = 96,
    parameter int unsigned INSN_W = 32,
    parameter logic [INSN_W-1:0] NOP_WORD = INSN_W'(32'h0000_0033),
    parameter int unsigned CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PAYLOAD_W-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAYLOAD_W-1:0] out_data,
    input  logic                 flush,
    output logic [CNT_W-1:0]     bubble_cnt,
    input  logic                 clr_cnt
);

    typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

    state_e               state_q, state_d;
    logic [PAYLOAD_W-1:0] m_q, m_d;
    logic [PAYLOAD_W-1:0] s_q, s_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 accept, send;

    // State encodes both valid bits, so S valid without M valid is unrepresentable.
    assign out_valid  = (state_q != StEmpty);
    assign in_ready   = (state_q != StFull);
    assign accept     = in_valid & in_ready;
    assign send       = out_valid & out_ready;
    assign bubble_cnt = cnt_q;

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        s_d     = s_q;
        case (state_q)
            StEmpty: begin
                if (accept) begin
                    m_d     = in_data;
                    state_d = StOne;
                end
            end
            StOne: begin
                if (accept && send) begin
                    m_d = in_data;
                end else if (accept) begin
                    s_d     = in_data;
                    state_d = StFull;
                end else if (send) begin
                    state_d = StEmpty;
                end
            end
            StFull: begin
                if (send) begin
                    m_d     = s_q;
                    state_d = StOne;
                end
            end
            default: state_d = StEmpty;
        endcase
        // Flush kills held beats but leaves M's payload visible above the instruction field.
        if (flush) begin
            state_d = StEmpty;
            m_d     = m_q;
            s_d     = s_q;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (clr_cnt) begin
            cnt_d = '0;
        end else if (!out_valid && out_ready && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_comb begin
        out_data = m_q;
        if (!out_valid) begin
            out_data[INSN_W-1:0] = NOP_WORD;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StEmpty;
            m_q     <= '0;
            s_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
